// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency 128-bit block memory answering cache requests with a one-cycle Ready pulse.
// Optional MEM_BOUNDS_CHECK_EN flags and suppresses accesses whose address bits lie above the block index.
package mem_pkg;
    localparam int MAINMEM_BLOCKS = 8192;
    localparam int BYTE_ADDR_BITS = 4;
    typedef struct packed {
        logic         Valid;
        logic         Wen;
        logic [31:0]  Addr;
        logic [127:0] WriteD;
    } CacheToMem_t;
    typedef struct packed {
        logic         Ready;
        logic [127:0] ReadD;
    } MemToCache_t;
endpackage

module main_mem_responder
    import mem_pkg::*;
#(
    parameter int    LATENCY   = 4,
    parameter int    BLOCKS    = MAINMEM_BLOCKS,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  CacheToMem_t Req,
    output MemToCache_t Resp,
    output logic        Busy,
    output logic        AddrErr
);
    localparam int IW = $clog2(BLOCKS);
    localparam int HW = 32 - BYTE_ADDR_BITS - IW;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            accept;
    logic            wen, wen_n;
    logic [IW-1:0]   idx, idx_n;
    logic [127:0]    wdata, wdata_n;
    logic [127:0]    read_d;
    logic            oob_n;
    logic            unused;
    logic [127:0]    mem [BLOCKS];

    assign accept  = state == IDLE && Req.Valid;
    assign wen_n   = accept ? Req.Wen : wen;
    assign idx_n   = accept ? Req.Addr[BYTE_ADDR_BITS +: IW] : idx;
    assign wdata_n = accept ? Req.WriteD : wdata;

`ifdef MEM_BOUNDS_CHECK_EN
    logic [HW-1:0] hi, hi_n;
    assign hi_n   = accept ? Req.Addr[31 -: HW] : hi;
    assign oob_n  = |hi_n;
    assign unused = ^Req.Addr[BYTE_ADDR_BITS-1:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hi <= '0;
        else        hi <= hi_n;
`else
    assign oob_n  = 1'b0;
    assign unused = ^{Req.Addr[31 -: HW], Req.Addr[BYTE_ADDR_BITS-1:0]};
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (Req.Valid) begin
                cnt_n   = CW'(LATENCY - 1);
                state_n = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n   = cnt - CW'(1);
                state_n = (cnt == CW'(1)) ? RESP : WAIT;
            end
            RESP:    state_n = HOLD;
            HOLD:    state_n = Req.Valid ? HOLD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ReadD is captured on the edge entering RESP so it stays stable outside RESP
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wen    <= 1'b0;
            idx    <= '0;
            wdata  <= '0;
            read_d <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wen   <= wen_n;
            idx   <= idx_n;
            wdata <= wdata_n;
            if (state_n == RESP)
                read_d <= wen_n ? wdata_n : oob_n ? '0 : mem[idx_n];
        end

    always_ff @(posedge clk)
        if (state == RESP && wen && !oob_n) mem[idx] <= wdata;

    assign Resp    = '{Ready: state == RESP, ReadD: read_d};
    assign Busy    = state != IDLE;
    assign AddrErr = state == RESP && oob_n;
endmodule
